ps2_keyboard_fifo: RTL and testbench

Memory-mapped PS/2 keyboard controller for the core's shared data_bus/address_bus/read/write peripheral bus. It sits alongside vga_text.
- Deserialises PS/2 frames from ps_kbdata/ps_kbclock.
- Checks framing and parity.
- Buffers scancodes in a parametrised FIFO.
- Exposes DATA, STATUS and CONTROL registers at a configurable base address.

---
 rtl/ps2_kbd_pkg.sv | 16 +
 rtl/ps2_keyboard_fifo_rx.sv | 82 ++++++++
 rtl/ps2_keyboard_fifo.sv | 106 ++++++++++
 tb/tb_ps2_keyboard_fifo.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: register map, STATUS/CONTROL bit positions and receiver states
package ps2_kbd_pkg;
  localparam int DATA_OFF = 0;
  localparam int STATUS_OFF = 8;
  localparam int CTRL_OFF = 16;
  localparam int ST_EMPTY = 8;
  localparam int ST_FULL = 9;
  localparam int ST_OVF = 10;
  localparam int ST_PAR = 11;
  localparam int ST_FRM = 12;
  localparam int ST_EN = 13;
  localparam int CT_FLUSH = 0;
  localparam int CT_CLR = 1;
  localparam int CT_EN = 2;
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} rx_state_e;
endpackage

// File: rtl/ps2_keyboard_fifo_rx.sv
// ps2_rx: synchronises the PS/2 lines, deserialises frames and flags parity/framing faults
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       ps_kbclock,
  input  logic       ps_kbdata,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       parity_err_pulse,
  output logic       frame_err_pulse
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] kclk_q, kdat_q;
  logic prev_q, fall, sclk, sdat, timeout, stop_ok, par_ok, in_check;
  rx_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  assign sclk = kclk_q[SYNC_STAGES-1];
  assign sdat = kdat_q[SYNC_STAGES-1];
  assign fall = prev_q && !sclk;
  always_ff @(posedge clock) begin
    if (!reset) begin
      kclk_q <= '1;
      kdat_q <= '1;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      tmo_q <= '0;
    end else begin
      kclk_q <= SYNC_STAGES'({kclk_q, ps_kbclock});
      kdat_q <= SYNC_STAGES'({kdat_q, ps_kbdata});
      prev_q <= sclk;
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      tmo_q <= tmo_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    tmo_d = '0;
    timeout = 1'b0;
    if (state_q == IDLE) begin
      if (fall && !sdat) begin
        state_d = SHIFT;
        cnt_d = '0;
      end
    end else if (state_q == SHIFT) begin
      if (fall) begin
        shift_d = {sdat, shift_q[9:1]};
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd9) ? CHECK : SHIFT;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        timeout = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      state_d = IDLE;
    end
    if (!en) state_d = IDLE;
  end
  // shift_q holds data[7:0], parity at [8], stop at [9] once the frame is complete
  assign stop_ok = shift_q[9];
  assign par_ok = ^shift_q[8:0];
  assign in_check = en && (state_q == CHECK);
  assign rx_byte = shift_q[7:0];
  assign byte_valid = in_check && stop_ok && par_ok;
  assign parity_err_pulse = in_check && stop_ok && !par_ok;
  assign frame_err_pulse = (in_check && !stop_ok) || (en && timeout);
endmodule

// File: rtl/ps2_keyboard_fifo.sv
// ps2_keyboard_fifo: memory-mapped PS/2 keyboard with scancode FIFO and sticky error flags
module ps2_keyboard_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h0000_0000_0000_2000,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  read,
  input  logic                  write,
  input  logic                  ps_kbdata,
  input  logic                  ps_kbclock,
  output logic                  irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] A_DATA = BASE_ADDR + ADDR_WIDTH'(DATA_OFF);
  localparam logic [ADDR_WIDTH-1:0] A_STAT = BASE_ADDR + ADDR_WIDTH'(STATUS_OFF);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = BASE_ADDR + ADDR_WIDTH'(CTRL_OFF);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, par_q, par_d, frm_q, frm_d, en_q, en_d, hit_q;
  logic byte_valid, perr, ferr, hit_data, hit_stat, hit_ctrl, ctrl_wr;
  logic empty, full, pop, flush, clr, accept, bus_oe;
  logic [7:0] rx_byte;
  logic [DATA_WIDTH-1:0] status, rdata;
  ps2_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock(clock), .reset(reset), .en(en_q), .ps_kbclock(ps_kbclock), .ps_kbdata(ps_kbdata),
    .byte_valid(byte_valid), .rx_byte(rx_byte), .parity_err_pulse(perr), .frame_err_pulse(ferr)
  );
  assign hit_data = read && (address == A_DATA);
  assign hit_stat = read && (address == A_STAT);
  assign hit_ctrl = read && (address == A_CTRL);
  assign ctrl_wr = write && !read && (address == A_CTRL);
  assign empty = (cnt_q == '0);
  assign full = (cnt_q == CW'(FIFO_DEPTH));
  // hit_q marks a continuing read so a held strobe pops only once
  assign pop = hit_data && !hit_q && !empty;
  assign flush = ctrl_wr && data[CT_FLUSH];
  assign clr = ctrl_wr && data[CT_CLR];
  assign accept = byte_valid && (!full || pop) && !flush;
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
    end else begin
      wr_d = accept ? wr_q + 1'b1 : wr_q;
      rd_d = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + CW'(accept) - CW'(pop);
    end
    ovf_d = (ovf_q && !clr) || (byte_valid && full && !pop && !flush);
    par_d = (par_q && !clr) || perr;
    frm_d = (frm_q && !clr) || ferr;
    en_d = ctrl_wr ? data[CT_EN] : en_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      par_q <= 1'b0;
      frm_q <= 1'b0;
      en_q <= 1'b1;
      hit_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      par_q <= par_d;
      frm_q <= frm_d;
      en_q <= en_d;
      hit_q <= hit_data;
    end
  end
  always_ff @(posedge clock) begin
    if (accept) mem_q[wr_q] <= rx_byte;
  end
  always_comb begin
    status = '0;
    status[CW-1:0] = cnt_q;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf_q;
    status[ST_PAR] = par_q;
    status[ST_FRM] = frm_q;
    status[ST_EN] = en_q;
    rdata = hit_data ? (empty ? '0 : DATA_WIDTH'({1'b1, mem_q[rd_q]})) : hit_stat ? status : '0;
  end
  assign bus_oe = hit_data || hit_stat || hit_ctrl;
  assign data = bus_oe ? rdata : 'z;
  assign irq = en_q && !empty;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// tb_ps2_keyboard_fifo: directed PS/2 frames and bus accesses with hand-computed expectations
module tb_ps2_keyboard_fifo;
  localparam logic [63:0] B = 64'h2000;
  localparam logic [63:0] S = 64'h2008;
  localparam logic [63:0] C = 64'h2010;
  logic clock = 0, reset = 0, read = 0, write = 0, ps_kbdata = 1, ps_kbclock = 1, tb_oe = 0, irq;
  logic [63:0] address = '0, tb_drv = '0;
  wire [63:0] data;
  int checks = 0, errors = 0;
  assign data = tb_oe ? tb_drv : 'z;
  ps2_keyboard_fifo #(.TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .address(address), .data(data), .read(read), .write(write),
    .ps_kbdata(ps_kbdata), .ps_kbclock(ps_kbclock), .irq(irq)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] st(input int cnt, input bit ovf, input bit par, input bit frm, input bit en);
    logic [63:0] v;
    v = 64'(cnt);
    if (cnt == 0) v[8] = 1'b1;
    if (cnt == 16) v[9] = 1'b1;
    v[10] = ovf;
    v[11] = par;
    v[12] = frm;
    v[13] = en;
    return v;
  endfunction
  task automatic ps_bit(input logic b);
    ps_kbdata = b;
    repeat (4) tick;
    ps_kbclock = 0;
    repeat (4) tick;
    ps_kbclock = 1;
  endtask
  task automatic send(input logic [7:0] v, input bit bad_par, input bit pop_at_push, input logic [63:0] head);
    ps_bit(1'b0);
    for (int i = 0; i < 8; i++) ps_bit(v[i]);
    ps_bit((~^v) ^ bad_par);
    ps_kbdata = 1;
    repeat (4) tick;
    ps_kbclock = 0;
    repeat (3) tick;
    if (pop_at_push) begin
      address = B;
      read = 1;
      #1;
      check("pop_at_push_data", data, head);
      tick;
      read = 0;
    end else begin
      tick;
    end
    repeat (3) tick;
    ps_kbclock = 1;
    repeat (4) tick;
  endtask
  task automatic rd(input logic [63:0] a, input logic [63:0] exp, input string tag);
    address = a;
    read = 1;
    #1;
    check(tag, data, exp);
    tick;
    read = 0;
    tick;
  endtask
  task automatic wr(input logic [63:0] v);
    address = C;
    tb_drv = v;
    tb_oe = 1;
    write = 1;
    tick;
    write = 0;
    tb_oe = 0;
    tick;
  endtask
  initial begin
    repeat (3) tick;
    check("rst_irq", {63'd0, irq}, 64'd0);
    check("rst_oe", {63'd0, dut.bus_oe}, 64'd0);
    reset = 1;
    tick;
    rd(S, st(0, 0, 0, 0, 1), "rst_status");
    send(8'h1C, 0, 0, 0);
    check("t1_irq", {63'd0, irq}, 64'd1);
    rd(S, st(1, 0, 0, 0, 1), "t1_status");
    rd(B, 64'h11C, "t1_data");
    rd(S, st(0, 0, 0, 0, 1), "t1_empty");
    rd(B, 64'h0, "t1_empty_data");
    check("t1_irq_low", {63'd0, irq}, 64'd0);
    send(8'h1C, 1, 0, 0);
    rd(S, st(0, 0, 1, 0, 1), "t2_parity");
    wr(64'h2);
    rd(S, st(0, 0, 0, 0, 0), "t2_cleared");
    wr(64'h4);
    rd(C, 64'h0, "t2_ctrl_read");
    for (int i = 0; i < 17; i++) send(8'(8'h30 + i), 0, 0, 0);
    check("t3_irq", {63'd0, irq}, 64'd1);
    rd(S, st(16, 1, 0, 0, 1), "t3_full");
    for (int i = 0; i < 16; i++) rd(B, 64'h100 | 64'(8'h30 + i), "t3_order");
    rd(S, st(0, 1, 0, 0, 1), "t3_drained");
    wr(64'h6);
    ps_bit(1'b0);
    ps_bit(1'b1);
    ps_bit(1'b0);
    ps_bit(1'b1);
    repeat (110) tick;
    rd(S, st(0, 0, 0, 1, 1), "t4_timeout");
    send(8'hF0, 0, 0, 0);
    rd(S, st(1, 0, 0, 1, 1), "t4_after");
    rd(B, 64'h1F0, "t4_data");
    wr(64'h6);
    send(8'hA1, 0, 0, 0);
    send(8'hB2, 0, 0, 0);
    address = B;
    read = 1;
    #1;
    check("t5_hold0", data, 64'h1A1);
    for (int k = 1; k < 5; k++) begin
      tick;
      check("t5_hold", data, 64'h1B2);
    end
    tick;
    read = 0;
    tick;
    rd(S, st(1, 0, 0, 0, 1), "t5_single_pop");
    rd(B, 64'h1B2, "t5_second");
    for (int i = 0; i < 15; i++) send(8'(8'h40 + i), 0, 0, 0);
    rd(S, st(15, 0, 0, 0, 1), "t5_fifteen");
    send(8'h4F, 0, 0, 0);
    send(8'h50, 0, 1, 64'h140);
    rd(S, st(16, 0, 0, 0, 1), "t5_pop_push_full");
    rd(B, 64'h141, "t5_head_after");
    wr(64'h5);
    rd(S, st(0, 0, 0, 0, 1), "t6_flush");
    wr(64'h0);
    send(8'h55, 0, 0, 0);
    check("t6_irq_dis", {63'd0, irq}, 64'd0);
    rd(S, st(0, 0, 0, 0, 0), "t6_disabled");
    wr(64'h4);
    send(8'h55, 0, 0, 0);
    send(8'h55, 1, 0, 0);
    rd(S, st(1, 0, 1, 0, 1), "t6_pre_reset");
    ps_bit(1'b0);
    ps_bit(1'b1);
    reset = 0;
    tick;
    check("t6_rst_irq", {63'd0, irq}, 64'd0);
    reset = 1;
    tick;
    check("t6_rst_oe", {63'd0, dut.bus_oe}, 64'd0);
    rd(S, st(0, 0, 0, 0, 1), "t6_rst_status");
    send(8'h1C, 0, 0, 0);
    rd(B, 64'h11C, "t6_after_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
